// File: rtl/cpu_pkg.sv
// Shared front-end definitions: data width, JAL opcode and the fetch FSM state type.
package cpu_pkg;

  localparam int         XLEN   = 32;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DISCARD
  } fetch_state_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO with push/pop/flush; head entry and count are driven straight from registers.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Flush wins over push/pop; DEPTH is a power of two so pointers wrap naturally.
  assign w_push = i_push & ~i_flush & ~w_full;
  assign w_pop  = i_pop & ~i_flush & ~o_empty;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding I-cache request feeding an in-order instruction queue.
// Optional JAL target prediction on enqueue when INST_FETCHER_JAL_PREDICT_EN is defined.
//
// state      | meaning
// FS_IDLE    | nothing outstanding; request pc when ready and a queue slot is free
// FS_WAIT    | request outstanding; its response will be enqueued
// FS_DISCARD | request outstanding but flushed; its response will be dropped
module inst_fetcher
  import cpu_pkg::*;
#(
  parameter int              IQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear,
  input  logic [XLEN-1:0] corr_inst_addr,
  output logic            icache_req,
  output logic [XLEN-1:0] icache_addr,
  input  logic            icache_valid,
  input  logic [XLEN-1:0] icache_inst,
  input  logic            dec_stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr
);

  localparam int CNT_W = $clog2(IQ_DEPTH + 1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_next;
  logic [XLEN-1:0]   w_target;
  logic              w_clr;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_room;
  logic [CNT_W-1:0]  w_count;
  logic [2*XLEN-1:0] w_head;

  // A paused block ignores flushes; only an arriving response is still absorbed.
  assign w_clr  = clear & rdy_in;
  assign w_pop  = ~w_empty & ~dec_stall & ~clear & rdy_in;
  assign w_room = (w_count < CNT_W'(IQ_DEPTH));

  assign icache_addr = r_pc;
  assign inst_valid  = ~w_empty;
  assign inst        = w_head[2*XLEN-1:XLEN];
  assign inst_addr   = w_head[XLEN-1:0];

`ifdef INST_FETCHER_JAL_PREDICT_EN
  logic [XLEN-1:0] w_j_imm;
  assign w_j_imm  = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                     icache_inst[30:21], 1'b0};
  assign w_target = (icache_inst[6:0] == OP_JAL) ? r_pc + w_j_imm : r_pc + 32'd4;
`else
  assign w_target = r_pc + 32'd4;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    icache_req   = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      FS_IDLE: begin
        if (w_clr) begin
          w_pc_next = corr_inst_addr;
        end else if (rdy_in && w_room) begin
          icache_req   = 1'b1;
          w_state_next = FS_WAIT;
        end
      end
      FS_WAIT: begin
        // r_pc still holds the address of the outstanding request here.
        if (w_clr) begin
          w_pc_next    = corr_inst_addr;
          w_state_next = icache_valid ? FS_IDLE : FS_DISCARD;
        end else if (icache_valid) begin
          w_push       = 1'b1;
          w_pc_next    = w_target;
          w_state_next = FS_IDLE;
        end
      end
      FS_DISCARD: begin
        if (w_clr) w_pc_next = corr_inst_addr;
        if (icache_valid) w_state_next = FS_IDLE;
      end
      default: w_state_next = FS_IDLE;
    endcase
  end

  inst_queue #(
    .DEPTH(IQ_DEPTH),
    .WIDTH(2 * XLEN)
  ) u_queue (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(w_clr),
    .i_data ({icache_inst, r_pc}),
    .o_head (w_head),
    .o_count(w_count),
    .o_empty(w_empty)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus a random run against a queue-based reference model.
module tb_inst_fetcher;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, icache_req, icache_valid, dec_stall, inst_valid;
  logic [31:0] corr_inst_addr, icache_addr, icache_inst, inst, inst_addr;

  inst_fetcher #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .corr_inst_addr(corr_inst_addr), .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_inst(icache_inst), .dec_stall(dec_stall),
    .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr)
  );

  always #5 clk_in = ~clk_in;

  // stimulus knobs
  bit          t_rst, t_rdy, t_clear, t_stall, t_stray;
  logic [31:0] t_corr;
  int          t_lat;
  // I-cache responder
  int          resp_cnt;
  logic [31:0] resp_addr;
  // reference model: pc, one outstanding slot, whether its response is wanted, FIFO of {inst,addr}
  logic [31:0] m_pc;
  bit          m_out, m_live;
  logic [63:0] m_q[$];
  // observed traffic for directed checks
  logic [31:0] req_log[$];
  logic [31:0] deq_log[$];
  int          total, bad;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h10) return 32'h0200_006F;  // jal x0, +0x20
    return {~a[24:0], 7'h13};
  endfunction

  function automatic logic [31:0] next_pc(logic [31:0] a, logic [31:0] w);
`ifdef INST_FETCHER_JAL_PREDICT_EN
    if (w[6:0] == 7'b1101111) return a + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
`endif
    return a + 32'd4;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit v, req_e, pop_e;
    v = (resp_cnt == 1) || t_stray;
    if (resp_cnt > 0) resp_cnt--;
    rst_in = t_rst; rdy_in = t_rdy; clear = t_clear; corr_inst_addr = t_corr;
    dec_stall = t_stall; icache_valid = v;
    icache_inst = v ? mem_word(resp_addr) : $urandom;
    #2;
    req_e = !m_out && t_rdy && !t_clear && (m_q.size() < DEPTH);
    pop_e = (m_q.size() != 0) && !t_stall && !t_clear && t_rdy;
    if (!t_rst) begin
      chk("icache_req", {31'b0, icache_req}, {31'b0, req_e});
      if (req_e) chk("icache_addr", icache_addr, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("inst", inst, m_q[0][63:32]);
        chk("inst_addr", inst_addr, m_q[0][31:0]);
      end
      if (icache_req) req_log.push_back(icache_addr);
      if (inst_valid && !dec_stall && !clear && rdy_in) deq_log.push_back(inst_addr);
    end
    @(posedge clk_in); #1;
    if (t_rst) begin
      m_pc = RPC; m_out = 0; m_live = 0; m_q.delete(); resp_cnt = 0;
    end else if (t_clear && t_rdy) begin
      m_q.delete(); m_pc = t_corr; m_live = 0;
      if (v) m_out = 0;
    end else begin
      if (pop_e) void'(m_q.pop_front());
      if (v && m_out) begin
        if (m_live) begin
          m_q.push_back({icache_inst, m_pc});
          m_pc = next_pc(m_pc, icache_inst);
        end
        m_out = 0; m_live = 0;
      end
      if (req_e) begin
        m_out = 1; m_live = 1; resp_cnt = t_lat; resp_addr = m_pc;
      end
    end
  endtask

  task automatic do_reset();
    t_rst = 1; t_rdy = 0; t_clear = 0; t_stall = 0; t_stray = 0; t_corr = 0; t_lat = 2;
    cycle(); cycle();
    t_rst = 0;
    req_log.delete(); deq_log.delete();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    total = 0; bad = 0; resp_cnt = 0; resp_addr = 0;
    m_pc = RPC; m_out = 0; m_live = 0;

    // reset values
    do_reset();
    #1;
    chk("rst_icache_req", {31'b0, icache_req}, 32'd0);
    chk("rst_icache_addr", icache_addr, RPC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'd0);

    // sequential fetch, 2-cycle latency, no stall
    t_rdy = 1; t_lat = 2;
    run(12);
    chk("seq_req_n", {31'b0, req_log.size() >= 3}, 32'd1);
    chk("seq_req0", req_log[0], 32'h0);
    chk("seq_req1", req_log[1], 32'h4);
    chk("seq_req2", req_log[2], 32'h8);
    chk("seq_deq_n", {31'b0, deq_log.size() >= 3}, 32'd1);
    chk("seq_deq0", deq_log[0], 32'h0);
    chk("seq_deq1", deq_log[1], 32'h4);
    chk("seq_deq2", deq_log[2], 32'h8);

    // stalled decoder fills the queue, then releases
    do_reset();
    t_rdy = 1; t_stall = 1; t_lat = 2;
    run(30);
    chk("full_req_n", req_log.size(), 32'd4);
    chk("full_req_now", {31'b0, icache_req}, 32'd0);
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_head", inst_addr, 32'h0);
    t_stall = 0;
    run(3);
    chk("full_req5_n", {31'b0, req_log.size() >= 5}, 32'd1);
    chk("full_req5", req_log[4], 32'h10);

    // flush while waiting; late response dropped
    do_reset();
    t_rdy = 1; t_lat = 3;
    cycle();
    t_clear = 1; t_corr = 32'h100;
    cycle();
    t_clear = 0;
    cycle(); cycle();
    chk("wclr_empty", {31'b0, inst_valid}, 32'd0);
    req_log.delete();
    cycle();
    chk("wclr_req_n", req_log.size(), 32'd1);
    chk("wclr_req", req_log[0], 32'h100);

    // flush and response in the same cycle
    do_reset();
    t_rdy = 1; t_lat = 1;
    cycle();
    t_clear = 1; t_corr = 32'h200;
    cycle();
    t_clear = 0;
    chk("same_empty", {31'b0, inst_valid}, 32'd0);
    req_log.delete();
    cycle();
    chk("same_req_n", req_log.size(), 32'd1);
    chk("same_req", req_log[0], 32'h200);

    // pause with two entries queued
    do_reset();
    t_rdy = 1; t_stall = 1; t_lat = 1;
    run(4);
    chk("pause_n0", req_log.size(), 32'd2);
    t_rdy = 0;
    run(5);
    chk("pause_n1", req_log.size(), 32'd2);
    chk("pause_head", inst_addr, 32'h0);
    chk("pause_deq", deq_log.size(), 32'd0);
    t_rdy = 1; t_stall = 0;
    run(2);
    chk("resume_deq0", deq_log[0], 32'h0);
    chk("resume_deq1", deq_log[1], 32'h4);

    // JAL at 0x10
    do_reset();
    t_rdy = 1; t_lat = 1;
    run(12);
    chk("jal_req_n", {31'b0, req_log.size() >= 6}, 32'd1);
`ifdef INST_FETCHER_JAL_PREDICT_EN
    chk("jal_next", req_log[5], 32'h30);
`else
    chk("jal_next", req_log[5], 32'h14);
`endif

    // reset mid-wait; stray response afterwards is ignored
    do_reset();
    t_rdy = 1; t_lat = 3;
    cycle();
    t_rst = 1;
    cycle();
    t_rst = 0; t_rdy = 0; t_stray = 1; resp_addr = 32'h0;
    cycle();
    t_stray = 0;
    chk("stray_valid", {31'b0, inst_valid}, 32'd0);
    chk("stray_pc", icache_addr, RPC);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      t_rdy   = ($urandom_range(0, 9) != 0);
      t_stall = ($urandom_range(0, 1) == 1);
      t_clear = ($urandom_range(0, 24) == 0);
      t_corr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      t_lat   = $urandom_range(1, 3);
      t_rst   = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
